// File: rtl/weight_tile_streamer.sv
// Host-loaded weight RAM that answers each weight-FIFO refill request with a
// burst of MUL_SIZE consecutive rows, tile after tile, from a latched base row.
module weight_tile_streamer #(
  parameter int MUL_SIZE  = 32,
  parameter int W_WIDTH   = 7,
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              host_wr_en_i,
  input  logic [ADDR_W-1:0]                 host_wr_addr_i,
  input  logic [MUL_SIZE*(W_WIDTH+1)-1:0]   host_wr_data_i,
  input  logic                              start_i,
  input  logic [ADDR_W-1:0]                 base_addr_i,
  input  logic [7:0]                        num_tiles_i,
  input  logic                              request_i,
  output logic                              sending_o,
  output logic [MUL_SIZE*(W_WIDTH+1)-1:0]   data_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o
);

  localparam int ROW_W = MUL_SIZE * (W_WIDTH + 1);
  localparam int CNT_W = $clog2(MUL_SIZE + 1);

  typedef enum logic [2:0] {IDLE, WAIT_REQ, PREFETCH, STREAM, FINISH} state_t;

  state_t             state, state_nxt;
  logic [ROW_W-1:0]   mem [MEM_DEPTH];
  logic [ADDR_W-1:0]  tile_addr;
  logic [ADDR_W-1:0]  rd_addr_p0;
  logic               vld_p0;
  logic [ROW_W-1:0]   rd_q_p1;
  logic               vld_p1;
  logic [CNT_W-1:0]   row_cnt;
  logic [7:0]         tile_cnt;
  logic [7:0]         num_tiles_q;
  logic               issue;
  logic               tile_end;
  logic               tile_last;
  logic               start_ok;
  logic               send_nxt;

  assign busy_o   = (state != IDLE);
  assign done_o   = (state == FINISH);
  assign start_ok = (state == IDLE) && start_i;
  // STREAM spans one pipeline-fill cycle plus MUL_SIZE output rows; the tile
  // ends on the cycle its last row sits on data_o.
  assign tile_end = (state == STREAM) && (row_cnt == CNT_W'(MUL_SIZE));
  assign send_nxt = vld_p1 && !rst_i;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    tile_last = (({1'b0, tile_cnt} + 9'd1) == {1'b0, num_tiles_q});
    case (state)
      IDLE:     if (start_i) state_nxt = (num_tiles_i == 8'd0) ? FINISH : WAIT_REQ;
      WAIT_REQ: if (request_i) begin
                  issue     = 1'b1;
                  state_nxt = PREFETCH;
                end
      PREFETCH: begin
                  issue     = 1'b1;
                  state_nxt = STREAM;
                end
      STREAM:   begin
                  issue = (row_cnt < CNT_W'(MUL_SIZE - 2));
                  if (tile_end) state_nxt = tile_last ? FINISH : WAIT_REQ;
                end
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      sending_o <= 1'b0;
      err_o     <= 1'b0;
      row_cnt   <= '0;
      tile_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      vld_p0    <= issue;
      vld_p1    <= vld_p0;
      sending_o <= vld_p1;
      err_o     <= busy_o && (host_wr_en_i || start_i);
      if (state == STREAM && !tile_end) row_cnt <= row_cnt + CNT_W'(1);
      else                              row_cnt <= '0;
      if (start_ok)      tile_cnt <= '0;
      else if (tile_end) tile_cnt <= tile_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_ok) num_tiles_q <= num_tiles_i;
    if (start_ok)      tile_addr <= base_addr_i;
    else if (tile_end) tile_addr <= tile_addr + ADDR_W'(MUL_SIZE);
  end

  // p0: read address; holds the tile start while waiting for a request
  always_ff @(posedge clk_i) begin
    if (state == WAIT_REQ) rd_addr_p0 <= tile_addr;
    else if (issue)        rd_addr_p0 <= rd_addr_p0 + ADDR_W'(1);
  end

  // p1: synchronous RAM read
  always_ff @(posedge clk_i) begin
    if (host_wr_en_i && state == IDLE) mem[host_wr_addr_i] <= host_wr_data_i;
    rd_q_p1 <= mem[rd_addr_p0];
  end

  // p2: output register, zero whenever no row is being sent
  always_ff @(posedge clk_i) begin
    data_o <= send_nxt ? rd_q_p1 : '0;
  end

endmodule

// File: tb/tb_weight_tile_streamer.sv
// Directed-plus-random bench for weight_tile_streamer against an address-arithmetic
// reference of the RAM contents and the request-to-row timing.
module tb_weight_tile_streamer;

  localparam int MUL_SIZE  = 32;
  localparam int W_WIDTH   = 7;
  localparam int MEM_DEPTH = 1024;
  localparam int ADDR_W    = 10;
  localparam int ROW_W     = MUL_SIZE * (W_WIDTH + 1);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              host_wr_en_i;
  logic [ADDR_W-1:0] host_wr_addr_i;
  logic [ROW_W-1:0]  host_wr_data_i;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [7:0]        num_tiles_i;
  logic              request_i;
  logic              sending_o;
  logic [ROW_W-1:0]  data_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  logic [ROW_W-1:0]  ref_mem [MEM_DEPTH];
  int vectors = 0;
  int miscompares = 0;

  weight_tile_streamer #(
    .MUL_SIZE(MUL_SIZE), .W_WIDTH(W_WIDTH), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_wr_en_i(host_wr_en_i), .host_wr_addr_i(host_wr_addr_i), .host_wr_data_i(host_wr_data_i),
    .start_i(start_i), .base_addr_i(base_addr_i), .num_tiles_i(num_tiles_i),
    .request_i(request_i), .sending_o(sending_o), .data_o(data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] fill(input logic [7:0] v);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < MUL_SIZE; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] rnd_row();
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ROW_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic host_write(input int a, input logic [ROW_W-1:0] d);
    host_wr_en_i = 1'b1; host_wr_addr_i = ADDR_W'(a); host_wr_data_i = d;
    tick();
    host_wr_en_i = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic start(input int b, input int n);
    start_i = 1'b1; base_addr_i = ADDR_W'(b); num_tiles_i = 8'(n);
    tick();
    start_i = 1'b0;
  endtask

  // One request and the burst it should produce: rows of the tile starting at
  // tb_base, first row two edges after the request is sampled.
  task automatic burst(input int tb_base, input bit last, input bit inject, input int rst_k);
    bit saw_done;
    request_i = 1'b1;
    tick();
    request_i = 1'b0;
    tick();
    chk("lat_idle", sending_o, 0);
    for (int k = 0; k < MUL_SIZE; k++) begin
      tick();
      chk("send_hi", sending_o, 1);
      chk("row", data_o, ref_mem[(tb_base + k) % MEM_DEPTH]);
      if (inject && k == 4) begin
        host_wr_en_i = 1'b1; host_wr_addr_i = 5; host_wr_data_i = fill(8'hAA);
      end
      if (inject && k == 5) begin
        chk("err_wr", err_o, 1);
        host_wr_en_i = 1'b0;
        start_i = 1'b1; base_addr_i = ADDR_W'($urandom_range(0, MEM_DEPTH - 1)); num_tiles_i = 8'd7;
      end
      if (inject && k == 6) begin
        chk("err_start", err_o, 1);
        start_i = 1'b0;
      end
      if (k == rst_k) begin
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_send", sending_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_busy", busy_o, 0);
        saw_done = 1'b0;
        repeat (40) begin
          tick();
          if (done_o || sending_o) saw_done = 1'b1;
        end
        chk("rst_quiet", saw_done, 0);
        return;
      end
    end
    tick();
    chk("send_lo", sending_o, 0);
    chk("done", done_o, last);
    chk("busy_end", busy_o, 1);
  endtask

  initial begin
    logic [ROW_W-1:0] d;
    logic [ROW_W-1:0] exp_q [$];
    int b, n, rows, gap, dones;
    bit prev, fin;

    rst_i = 1'b1; host_wr_en_i = 1'b0; host_wr_addr_i = '0; host_wr_data_i = '0;
    start_i = 1'b0; base_addr_i = '0; num_tiles_i = '0; request_i = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_sending", sending_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_busy_o", busy_o, 0);
    chk("rst_done_o", done_o, 0);
    chk("rst_err_o", err_o, 0);
    rst_i = 1'b0;

    for (int a = 0; a < MEM_DEPTH; a++) host_write(a, (a < MUL_SIZE) ? fill(8'(a)) : rnd_row());

    // single tile; a host write in the start cycle is still performed
    d = rnd_row();
    host_wr_en_i = 1'b1; host_wr_addr_i = 40; host_wr_data_i = d;
    start(0, 1);
    host_wr_en_i = 1'b0;
    ref_mem[40] = d;
    chk("busy_wait", busy_o, 1);
    tick();
    chk("wait_quiet", sending_o, 0);
    burst(0, 1'b1, 1'b0, -1);
    tick();
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);

    // two tiles wrapping past the top of the RAM
    start(1008, 2);
    repeat ($urandom_range(0, 3)) tick();
    burst(1008, 1'b0, 1'b0, -1);
    repeat ($urandom_range(0, 3)) begin
      tick();
      chk("gap_quiet", sending_o, 0);
    end
    burst(1008 + MUL_SIZE, 1'b1, 1'b0, -1);
    tick();

    // zero tiles
    start(0, 0);
    chk("zero_busy", busy_o, 1);
    chk("zero_done", done_o, 1);
    chk("zero_send", sending_o, 0);
    tick();
    chk("zero_idle", busy_o, 0);
    chk("zero_done_lo", done_o, 0);

    // rejected write and start during a stream; latched base survives
    b = $urandom_range(0, MEM_DEPTH - 1);
    start(b, 2);
    burst(b, 1'b0, 1'b1, -1);
    burst(b + MUL_SIZE, 1'b1, 1'b0, -1);
    tick();
    chk("rej_idle", busy_o, 0);
    start(0, 1);
    burst(0, 1'b1, 1'b0, -1);
    tick();

    // reset on the tenth row, then RAM contents still stream correctly
    b = $urandom_range(0, MEM_DEPTH - 1);
    start(b, 1);
    burst(b, 1'b0, 1'b0, 9);
    b = $urandom_range(0, MEM_DEPTH - 1);
    start(b, 1);
    burst(b, 1'b1, 1'b0, -1);
    tick();

    // request held high across three tiles
    b = $urandom_range(0, MEM_DEPTH - 1);
    for (int t = 0; t < 3; t++)
      for (int k = 0; k < MUL_SIZE; k++) exp_q.push_back(ref_mem[(b + t * MUL_SIZE + k) % MEM_DEPTH]);
    start(b, 3);
    request_i = 1'b1;
    rows = 0; gap = 0; dones = 0; prev = 1'b0; fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      tick();
      if (sending_o) begin
        if (!prev && rows > 0) chk("held_gap", gap, 3);
        if (exp_q.size() == 0) chk("held_extra", sending_o, 0);
        else chk("held_row", data_o, exp_q.pop_front());
        rows++;
        gap = 0;
      end else begin
        gap++;
      end
      prev = sending_o;
      if (done_o) begin
        dones++;
        fin = 1'b1;
      end
    end
    request_i = 1'b0;
    chk("held_rows", rows, 3 * MUL_SIZE);
    chk("held_done", dones, 1);
    tick();
    chk("held_idle", busy_o, 0);

    // random bases, tile counts and request spacing
    for (int it = 0; it < 3; it++) begin
      b = $urandom_range(0, MEM_DEPTH - 1);
      n = $urandom_range(1, 3);
      start(b, n);
      for (int t = 0; t < n; t++) begin
        repeat ($urandom_range(0, 4)) begin
          tick();
          chk("rnd_quiet", sending_o, 0);
        end
        burst(b + t * MUL_SIZE, t == n - 1, 1'b0, -1);
      end
      tick();
      chk("rnd_idle", busy_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
